hci_ecc_scrubber: RTL and testbench

- Background scrubber and port arbiter placed between the HCI interconnect and one ECC-protected memory bank wrapper.
- Interleaves periodic scrub reads with normal traffic, and writes corrected data back when a correctable error is reported.
- Skips writeback on uncorrectable errors.
- Emits per-event pulses that feed the ECC error counters in the ECC manager register file.

---
 rtl/hci_ecc_scrubber.sv | 175 +++++++++++++++++
 tb/tb_hci_ecc_scrubber.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_ecc_scrubber.sv
// Background ECC scrubber and bank port arbiter between the HCI interconnect and one
// ECC-protected bank: periodic scrub reads, writeback of corrected words, error pulses.
module hci_ecc_scrubber #(
    parameter int unsigned BankWords = 1024,
    parameter int unsigned AW        = $clog2(BankWords),
    parameter int unsigned DW        = 32,
    parameter int unsigned MaxStall  = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            scrub_enable_i,
    input  logic [31:0]     scrub_interval_i,
    input  logic            in_req_i,
    output logic            in_gnt_o,
    input  logic [AW-1:0]   in_add_i,
    input  logic            in_wen_i,
    input  logic [DW-1:0]   in_wdata_i,
    input  logic [DW/8-1:0] in_be_i,
    output logic [DW-1:0]   in_r_data_o,
    output logic            in_r_valid_o,
    output logic            out_req_o,
    input  logic            out_gnt_i,
    output logic [AW-1:0]   out_add_o,
    output logic            out_wen_o,
    output logic [DW-1:0]   out_wdata_o,
    output logic [DW/8-1:0] out_be_o,
    input  logic [DW-1:0]   out_r_data_i,
    input  logic            out_r_valid_i,
    input  logic            ecc_correctable_err_i,
    input  logic            ecc_uncorrectable_err_i,
    output logic            scrub_correctable_o,
    output logic            scrub_uncorrectable_o,
    output logic            scrub_pass_done_o
);

    localparam int unsigned SW = $clog2(MaxStall + 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            owner_q, owner_d;
    logic [DW-1:0]   wb_data_q, wb_data_d;

    logic            scrub_active;
    logic            forced;
    logic            scrub_drive;
    logic            advance;
    logic            corr_c, uncorr_c, pass_c;

    // A disable only withdraws a pending read; an accepted writeback always completes.
    assign scrub_active = (state_q == WRITE) || ((state_q == READ) && scrub_enable_i);
    assign forced       = (stall_q == SW'(MaxStall));
    assign scrub_drive  = scrub_active && (!in_req_i || forced);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        wb_data_d = wb_data_q;
        owner_d   = scrub_drive && out_gnt_i;
        advance   = 1'b0;
        corr_c    = 1'b0;
        uncorr_c  = 1'b0;
        pass_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall_d = '0;
                if (!scrub_enable_i) begin
                    cnt_d = '0;
                end else if (cnt_q == scrub_interval_i) begin
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    cnt_d = 32'(cnt_q + 32'd1);
                end
            end
            READ: begin
                if (!scrub_enable_i) begin
                    state_d = IDLE;
                    stall_d = '0;
                end else if (scrub_drive) begin
                    if (out_gnt_i) begin
                        state_d = WAIT;
                        stall_d = '0;
                    end
                end else begin
                    stall_d = SW'(stall_q + SW'(1));
                end
            end
            WAIT: begin
                if (out_r_valid_i && ecc_uncorrectable_err_i) begin
                    uncorr_c = 1'b1;
                    advance  = 1'b1;
                    state_d  = IDLE;
                end else if (out_r_valid_i && ecc_correctable_err_i) begin
                    corr_c    = 1'b1;
                    wb_data_d = out_r_data_i;
                    state_d   = WRITE;
                end else begin
                    advance = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (scrub_drive) begin
                    if (out_gnt_i) begin
                        advance = 1'b1;
                        stall_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    stall_d = SW'(stall_q + SW'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (addr_q == AW'(BankWords - 1)) begin
                addr_d = '0;
                pass_c = 1'b1;
            end else begin
                addr_d = AW'(addr_q + AW'(1));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            stall_q   <= '0;
            owner_q   <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            owner_q   <= owner_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Bank port mux: interconnect passes straight through unless the scrubber owns the cycle.
    always_comb begin
        out_req_o   = in_req_i;
        out_add_o   = in_add_i;
        out_wen_o   = in_wen_i;
        out_wdata_o = in_wdata_i;
        out_be_o    = in_be_i;
        in_gnt_o    = out_gnt_i;
        if (scrub_drive) begin
            out_req_o   = 1'b1;
            out_add_o   = addr_q;
            out_wen_o   = (state_q == READ);
            out_wdata_o = wb_data_q;
            out_be_o    = '1;
            in_gnt_o    = 1'b0;
        end
    end

    assign in_r_valid_o          = owner_q ? 1'b0 : out_r_valid_i;
    assign in_r_data_o           = owner_q ? '0 : out_r_data_i;
    assign scrub_correctable_o   = corr_c;
    assign scrub_uncorrectable_o = uncorr_c;
    assign scrub_pass_done_o     = pass_c;

endmodule

// File: tb/tb_hci_ecc_scrubber.sv
// Directed self-checking bench for hci_ecc_scrubber with a 4-word bank model and
// one-cycle read response, error injection on a chosen address.
module tb_hci_ecc_scrubber;

    localparam int unsigned BW_WORDS = 4;
    localparam int unsigned AW       = 2;
    localparam int unsigned DW       = 32;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [31:0]     interval;
    logic            in_req, in_gnt, in_wen, in_r_valid;
    logic [AW-1:0]   in_add;
    logic [DW-1:0]   in_wdata, in_r_data;
    logic [3:0]      in_be;
    logic            out_req, out_gnt, out_wen;
    logic [AW-1:0]   out_add;
    logic [DW-1:0]   out_wdata;
    logic [3:0]      out_be;
    logic [DW-1:0]   rdata;
    logic            rvalid, corr_err, uncorr_err;
    logic            p_corr, p_uncorr, p_pass;

    hci_ecc_scrubber #(.BankWords(BW_WORDS), .DW(DW), .MaxStall(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .scrub_enable_i(en), .scrub_interval_i(interval),
        .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
        .in_wdata_i(in_wdata), .in_be_i(in_be), .in_r_data_o(in_r_data), .in_r_valid_o(in_r_valid),
        .out_req_o(out_req), .out_gnt_i(out_gnt), .out_add_o(out_add), .out_wen_o(out_wen),
        .out_wdata_o(out_wdata), .out_be_o(out_be), .out_r_data_i(rdata), .out_r_valid_i(rvalid),
        .ecc_correctable_err_i(corr_err), .ecc_uncorrectable_err_i(uncorr_err),
        .scrub_correctable_o(p_corr), .scrub_uncorrectable_o(p_uncorr), .scrub_pass_done_o(p_pass)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank model, injection controls and event logs
    logic [DW-1:0] mem [BW_WORDS];
    logic [AW-1:0] inj_add;
    logic [1:0]    inj_kind;
    logic [DW-1:0] inj_data;
    int            cyc = 0;
    int            n_corr = 0, n_uncorr = 0, n_pass = 0, n_rvalid = 0;
    int            rd_log[$];
    int            rd_cyc[$];
    logic [37:0]   wr_log[$];

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rvalid     <= out_req && out_gnt;
        rdata      <= '0;
        corr_err   <= 1'b0;
        uncorr_err <= 1'b0;
        if (out_req && out_gnt) begin
            if (out_wen) begin
                if (inj_kind != 2'd0 && out_add == inj_add) begin
                    rdata      <= inj_data;
                    corr_err   <= (inj_kind == 2'd1);
                    uncorr_err <= (inj_kind == 2'd2);
                end else begin
                    rdata <= mem[out_add];
                end
                if (!in_req) begin
                    rd_log.push_back(int'(out_add));
                    rd_cyc.push_back(cyc);
                end
            end else begin
                for (int b = 0; b < 4; b++)
                    if (out_be[b]) mem[out_add][8*b +: 8] <= out_wdata[8*b +: 8];
                if (!in_req) wr_log.push_back({out_add, out_wdata, out_be});
            end
        end
        if (p_corr)     n_corr   <= n_corr + 1;
        if (p_uncorr)   n_uncorr <= n_uncorr + 1;
        if (p_pass)     n_pass   <= n_pass + 1;
        if (in_r_valid) n_rvalid <= n_rvalid + 1;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        en = 1'b0; interval = '0; in_req = 1'b0; in_add = '0; in_wen = 1'b1;
        in_wdata = '0; in_be = '0; out_gnt = 1'b1; inj_kind = 2'd0; inj_add = '0; inj_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_rd(input int n, input string tag);
        int budget = 200;
        while (rd_log.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(tag, 64'(rd_log.size() >= n), 64'd1);
    endtask

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] add;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int base, wbase, cbase, ubase, pbase, vbase, first_deny, nd;
        logic [AW-1:0] deny_add;
        logic deny_wen, found;

        vecs[0] = '{1'b0, 2'd0, 32'h11111111, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 2'd1, 32'h22222222, 4'hF, 32'h0};
        vecs[2] = '{1'b0, 2'd2, 32'h33333333, 4'hF, 32'h0};
        vecs[3] = '{1'b0, 2'd3, 32'h44444444, 4'hF, 32'h0};
        vecs[4] = '{1'b0, 2'd1, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[5] = '{1'b1, 2'd1, 32'h0,        4'hF, 32'h22BB22DD};
        vecs[6] = '{1'b1, 2'd3, 32'h0,        4'hF, 32'h44444444};
        vecs[7] = '{1'b0, 2'd3, 32'h55667788, 4'h8, 32'h0};
        vecs[8] = '{1'b1, 2'd3, 32'h0,        4'hF, 32'h55444444};
        vecs[9] = '{1'b1, 2'd0, 32'h0,        4'hF, 32'h11111111};

        // Reset state and asynchronous bypass
        clear_inputs();
        out_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("rst_out_req", 64'(out_req), 64'd0);
        check("rst_in_gnt", 64'(in_gnt), 64'd0);
        check("rst_rvalid_pulses", 64'({in_r_valid, p_corr, p_uncorr, p_pass}), 64'd0);
        in_req = 1'b1; in_add = 2'd2; in_wen = 1'b0; in_wdata = 32'h12345678; in_be = 4'h5; out_gnt = 1'b1;
        #1;
        check("rst_bypass", 64'({out_req, out_add, out_wen, out_wdata, out_be, in_gnt}),
              64'({1'b1, 2'd2, 1'b0, 32'h12345678, 4'h5, 1'b1}));
        clear_inputs();

        // Traffic only: bank sees identical transactions, responses 1 cycle after grant
        do_reset();
        cbase = n_corr; ubase = n_uncorr; pbase = n_pass;
        for (int i = 0; i < 10; i++) begin
            in_req = 1'b1; in_add = vecs[i].add; in_wen = vecs[i].wen;
            in_wdata = vecs[i].wdata; in_be = vecs[i].be;
            #1;
            check($sformatf("byp_bank%0d", i), 64'({out_req, out_add, out_wen, out_wdata, out_be, in_gnt}),
                  64'({1'b1, vecs[i].add, vecs[i].wen, vecs[i].wdata, vecs[i].be, 1'b1}));
            @(negedge clk);
            in_req = 1'b0;
            #1;
            check($sformatf("byp_rvalid%0d", i), 64'(in_r_valid), 64'd1);
            if (vecs[i].wen) check($sformatf("byp_rdata%0d", i), 64'(in_r_data), 64'(vecs[i].exp));
            @(negedge clk);
        end
        check("byp_no_pulses", 64'((n_corr - cbase) + (n_uncorr - ubase) + (n_pass - pbase)), 64'd0);

        // Clean scrub, interval 3
        clear_inputs();
        en = 1'b1; interval = 32'd3;
        do_reset();
        base = rd_log.size(); pbase = n_pass; vbase = n_rvalid; cbase = n_corr; ubase = n_uncorr;
        wait_rd(base + 5, "clean_reads_seen");
        en = 1'b0;
        for (int i = 0; i < 5; i++)
            check($sformatf("clean_addr%0d", i), 64'(rd_log[base+i]), 64'(i % 4));
        for (int i = 1; i < 5; i++)
            check($sformatf("clean_gap%0d", i), 64'(rd_cyc[base+i] - rd_cyc[base+i-1]), 64'd6);
        check("clean_pass_cnt", 64'(n_pass - pbase), 64'd1);
        check("clean_no_rvalid", 64'(n_rvalid - vbase), 64'd0);
        check("clean_no_err", 64'((n_corr - cbase) + (n_uncorr - ubase)), 64'd0);

        // Correctable error at address 2 -> writeback of corrected data
        clear_inputs();
        inj_add = 2'd2; inj_kind = 2'd1; inj_data = 32'hDEADBEEF;
        en = 1'b1;
        do_reset();
        base = rd_log.size(); wbase = wr_log.size(); cbase = n_corr;
        wait_rd(base + 4, "corr_reads_seen");
        en = 1'b0;
        check("corr_wr_count", 64'(wr_log.size() - wbase), 64'd1);
        check("corr_wr_entry", 64'(wr_log[wbase]), 64'({2'd2, 32'hDEADBEEF, 4'hF}));
        check("corr_pulse", 64'(n_corr - cbase), 64'd1);
        check("corr_next_read", 64'(rd_log[base+3]), 64'd3);
        check("corr_mem", 64'(mem[2]), 64'hDEADBEEF);

        // Uncorrectable error at address 1 -> no writeback, address advances
        clear_inputs();
        inj_add = 2'd1; inj_kind = 2'd2; inj_data = 32'h0BADBAD0;
        en = 1'b1;
        do_reset();
        base = rd_log.size(); wbase = wr_log.size(); ubase = n_uncorr; cbase = n_corr;
        wait_rd(base + 3, "uncorr_reads_seen");
        en = 1'b0;
        check("uncorr_addr1", 64'(rd_log[base+1]), 64'd1);
        check("uncorr_next", 64'(rd_log[base+2]), 64'd2);
        check("uncorr_no_wr", 64'(wr_log.size() - wbase), 64'd0);
        check("uncorr_pulse", 64'(n_uncorr - ubase), 64'd1);
        check("uncorr_no_corr", 64'(n_corr - cbase), 64'd0);

        // Starvation: traffic held on address 3, scrub forced on the 9th READ cycle
        clear_inputs();
        en = 1'b1; in_req = 1'b1; in_add = 2'd3; in_wen = 1'b1;
        do_reset();
        first_deny = 0; deny_add = '1; deny_wen = 1'b0;
        for (int k = 1; k <= 30 && first_deny == 0; k++) begin
            #1;
            if (!in_gnt) begin
                first_deny = k; deny_add = out_add; deny_wen = out_wen;
            end
            @(negedge clk);
        end
        check("starve_deny_cycle", 64'(first_deny), 64'd10);
        check("starve_scrub_rd", 64'({deny_add, deny_wen}), 64'({2'd0, 1'b1}));
        #1;
        check("starve_gnt_after", 64'(in_gnt), 64'd1);
        check("starve_owner_hide", 64'(in_r_valid), 64'd0);
        @(negedge clk); #1;
        check("starve_resp", 64'({in_r_valid, in_r_data}), 64'({1'b1, 32'h55444444}));

        // Disable while READ is starved: back to IDLE, address unchanged
        clear_inputs();
        en = 1'b1; in_req = 1'b1; in_add = 2'd3; in_wen = 1'b1;
        do_reset();
        repeat (4) @(negedge clk);
        en = 1'b0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            #1;
            if (!in_gnt) nd++;
            @(negedge clk);
        end
        check("dis_no_force", 64'(nd), 64'd0);
        in_req = 1'b0; en = 1'b1;
        base = rd_log.size();
        wait_rd(base + 1, "dis_resume_seen");
        en = 1'b0;
        check("dis_addr_kept", 64'(rd_log[base]), 64'd0);

        // Reset during WRITE: async return to bypass, writeback lost, address restarts
        clear_inputs();
        inj_add = 2'd1; inj_kind = 2'd1; inj_data = 32'hCAFEF00D;
        en = 1'b1;
        do_reset();
        wbase = wr_log.size();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            #1;
            if (out_req && !out_wen) found = 1'b1;
            else @(negedge clk);
        end
        check("rstw_write_seen", 64'({found, out_add, in_gnt}), 64'({1'b1, 2'd1, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_async", 64'({out_req, in_gnt, p_corr, p_uncorr, p_pass}), 64'({1'b0, 1'b1, 3'b000}));
        inj_kind = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        base = rd_log.size();
        wait_rd(base + 1, "rstw_resume_seen");
        en = 1'b0;
        check("rstw_addr0", 64'(rd_log[base]), 64'd0);
        check("rstw_wb_lost", 64'(wr_log.size() - wbase), 64'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
